// File: rtl/eth_stats_histogram_if.sv
// Per-frame completion bus from the stats counter into the histogram.
// Latency: none, plain wires.
// Backpressure: none; the producer pulses valid and the consumer always accepts.
interface eth_stats_histogram_if;
  logic        valid;
  logic [15:0] frame_length;
  logic        frame_good;

  modport master (output valid, frame_length, frame_good);
  modport slave  (input  valid, frame_length, frame_good);
endinterface

// File: rtl/eth_stats_histogram.sv
// Frame-length histogram plus good/bad/byte counters with an atomic shadow bank.
// Latency: frame at edge N is visible to a snapshot at N+2; reads are registered, 1 cycle.
// Backpressure: none; one frame per cycle is always accepted, live counting never stalls.
module eth_stats_histogram #(
  parameter int C_NUM_BINS      = 8,
  parameter int C_BIN_SHIFT     = 8,
  parameter int C_COUNTER_WIDTH = 64,
  parameter int C_SATURATE      = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               srst,
  input  logic                               enable,
  eth_stats_histogram_if.slave               frm,
  input  logic                               snapshot,
  input  logic [$clog2(C_NUM_BINS+3)-1:0]    rd_addr,
  output logic [C_COUNTER_WIDTH-1:0]         rd_data,
  output logic [2:0]                         stats_id,
  output logic                               overflow
);

  localparam int NUM_CNT = C_NUM_BINS + 3;
  localparam int IW      = $clog2(C_NUM_BINS);
  localparam int GOOD_A  = C_NUM_BINS;
  localparam int BAD_A   = C_NUM_BINS + 1;
  localparam int BYTES_A = C_NUM_BINS + 2;
  localparam int CW      = C_COUNTER_WIDTH;

  // Returns {overflowed, new_value}; the sum is formed wide enough that any
  // carry out of the counter width is seen, then wrapped or clamped.
  function automatic logic [CW:0] add_cnt(input logic [CW-1:0] a, input logic [15:0] inc);
    logic [CW+16:0] sum;
    logic           ovf;
    sum = {17'd0, a} + {{(CW+1){1'b0}}, inc};
    ovf = |sum[CW+16:CW];
    if (ovf && (C_SATURATE != 0)) return {1'b1, {CW{1'b1}}};
    return {ovf, sum[CW-1:0]};
  endfunction

  logic            s1_vld;
  logic [15:0]     s1_len;
  logic            s1_good;
  logic [IW-1:0]   s1_idx;
  logic [15:0]     len_bin;
  logic [IW-1:0]   frm_idx;

  logic [CW-1:0]   cnt     [NUM_CNT];
  logic [CW-1:0]   cnt_nxt [NUM_CNT];
  logic [CW-1:0]   shadow  [NUM_CNT];
  logic            ovf_hit;
  logic [CW-1:0]   rd_mux;

  // Bin index: length divided by bin width, oversize frames land in the last bin.
  always_comb begin
    len_bin = frm.frame_length >> C_BIN_SHIFT;
    if (len_bin > 16'(C_NUM_BINS - 1)) frm_idx = IW'(C_NUM_BINS - 1);
    else                               frm_idx = len_bin[IW-1:0];
  end

  // Stage 1: capture an accepted frame; frames offered while disabled are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_len  <= '0;
      s1_good <= 1'b0;
      s1_idx  <= '0;
    end else if (srst) begin
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= frm.valid & enable;
      if (frm.valid && enable) begin
        s1_len  <= frm.frame_length;
        s1_good <= frm.frame_good;
        s1_idx  <= frm_idx;
      end
    end
  end

  // Stage 2 next-state: apply the captured frame to the live counters.
  always_comb begin
    logic [CW:0] r;
    r       = '0;
    ovf_hit = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) cnt_nxt[i] = cnt[i];
    if (s1_vld) begin
      if (s1_good) begin
        r = add_cnt(cnt[s1_idx], 16'd1);
        cnt_nxt[s1_idx] = r[CW-1:0];
        ovf_hit = ovf_hit | r[CW];
        r = add_cnt(cnt[GOOD_A], 16'd1);
        cnt_nxt[GOOD_A] = r[CW-1:0];
        ovf_hit = ovf_hit | r[CW];
      end else begin
        r = add_cnt(cnt[BAD_A], 16'd1);
        cnt_nxt[BAD_A] = r[CW-1:0];
        ovf_hit = ovf_hit | r[CW];
      end
      r = add_cnt(cnt[BYTES_A], s1_len);
      cnt_nxt[BYTES_A] = r[CW-1:0];
      ovf_hit = ovf_hit | r[CW];
    end
  end

  // Live and shadow banks; the shadow takes pre-edge live values so a same-edge commit lands in the next snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else if (srst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (snapshot) shadow[i] <= cnt[i];
      end
    end
  end

  // Sequence number bumps on every commit; overflow is sticky until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_id <= 3'd0;
      overflow <= 1'b0;
    end else if (srst) begin
      stats_id <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (s1_vld)  stats_id <= stats_id + 3'd1;
      if (ovf_hit) overflow <= 1'b1;
    end
  end

  // Shadow read mux; unmapped addresses return zero.
  always_comb begin
    rd_mux = '0;
    if (int'(rd_addr) < NUM_CNT) rd_mux = shadow[rd_addr];
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rd_data <= '0;
    else if (srst) rd_data <= '0;
    else           rd_data <= rd_mux;
  end

endmodule
